// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-bit, 4-register CPU control slice.
// Holds datapath widths, instruction field positions, opcode values,
// the sequencer state type and small opcode classification helpers.
package cpu_pkg;

  localparam int DATA_W = 5;
  localparam int PC_W   = 5;
  localparam int IR_W   = 12;

  // Instruction fields
  localparam int OP_HI  = 11;
  localparam int OP_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 6;
  localparam int RA_HI  = 5;
  localparam int RA_LO  = 4;
  localparam int RB_HI  = 3;
  localparam int RB_LO  = 2;
  localparam int IMM_HI = 4;
  localparam int IMM_LO = 0;

  // Opcodes
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_BRZ = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_e;

  // Ops 1..8 produce a register result and update the flags.
  function automatic logic writes_reg(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LDI);
  endfunction

  // Opcodes B..E are undefined.
  function automatic logic is_undefined(input logic [3:0] op);
    return (op > OP_JMP) && (op < OP_HLT);
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Bus bundle between the control unit, instruction memory and register set.
//   imem_addr/imem_req/imem_ack/imem_data : instruction fetch handshake
//   Ra/Rb -> a/b                          : register-set read ports
//   Wr/Wrd/reg_en                         : register-set write port
// master = control unit side, slave = memory / register-set side.
interface cpu_control_unit_if;
  import cpu_pkg::*;

  logic [PC_W-1:0]   imem_addr;
  logic              imem_req;
  logic              imem_ack;
  logic [IR_W-1:0]   imem_data;
  logic [1:0]        Ra;
  logic [1:0]        Rb;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [1:0]        Wr;
  logic [DATA_W-1:0] Wrd;
  logic              reg_en;

  modport master (
    output imem_addr, imem_req,
    input  imem_ack, imem_data,
    output Ra, Rb,
    input  a, b,
    output Wr, Wrd, reg_en
  );

  modport slave (
    input  imem_addr, imem_req,
    output imem_ack, imem_data,
    input  Ra, Rb,
    output a, b,
    input  Wr, Wrd, reg_en
  );

endinterface

// File: rtl/cpu_control_unit_alu.sv
// Combinational 5-bit ALU.
//   op     : opcode
//   a, b   : register operands
//   imm5   : immediate for LDI
//   result : op result (mod 32)
//   carry  : ADD carry-out / SUB borrow (a < b); 0 for other ops
//   zero   : result == 0
module alu_5bit
  import cpu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm5,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Top bit of the widened difference is the unsigned borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin result = sum[DATA_W-1:0];  carry = sum[DATA_W];  end
      OP_SUB: begin result = diff[DATA_W-1:0]; carry = diff[DATA_W]; end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_MOV: result = a;
      OP_LDI: result = imm5;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the 5-bit CPU.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fetch handshake, register-set read selects/data, write port
//   zero_flag  : last ALU result was zero (ops 1..8)
//   carry_flag : carry/borrow of last ADD/SUB (cleared by ops 3..8)
//   illegal    : one-cycle pulse in DECODE for opcodes B..E
//   halted     : core stopped by HLT; only reset restarts it
module cpu_control_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  cpu_control_unit_if.master bus,
  output logic               zero_flag,
  output logic               carry_flag,
  output logic               illegal,
  output logic               halted
);

  state_e            state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   next_pc;
  logic [IR_W-1:0]   ir;
  logic [3:0]        op;
  logic [DATA_W-1:0] imm5;
  logic              branch_taken;
  logic              req_q;
  logic              reg_en_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  assign op   = ir[OP_HI:OP_LO];
  assign imm5 = ir[IMM_HI:IMM_LO];

  // ir only changes on a fetch ack, so the selects are stable DECODE..WRITEBACK.
  assign bus.Ra = (op == OP_BRZ) ? ir[RD_HI:RD_LO] : ir[RA_HI:RA_LO];
  assign bus.Rb = ir[RB_HI:RB_LO];

  assign bus.imem_addr = pc;
  assign bus.imem_req  = req_q;
  // Gated so a reset asserted during WRITEBACK cancels the write on that edge.
  assign bus.reg_en    = reg_en_q & rst_n;

  alu_5bit u_alu (
    .op     (op),
    .a      (bus.a),
    .b      (bus.b),
    .imm5   (imm5),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    next_pc = pc + PC_W'(1);
    if ((op == OP_JMP) || ((op == OP_BRZ) && branch_taken))
      next_pc = imm5;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      pc           <= '0;
      ir           <= '0;
      branch_taken <= 1'b0;
      req_q        <= 1'b0;
      reg_en_q     <= 1'b0;
      bus.Wr       <= '0;
      bus.Wrd      <= '0;
      zero_flag    <= 1'b0;
      carry_flag   <= 1'b0;
      illegal      <= 1'b0;
      halted       <= 1'b0;
    end else begin
      illegal  <= 1'b0;
      reg_en_q <= 1'b0;
      case (state)
        S_FETCH: begin
          // req is raised one cycle after reset; afterwards WRITEBACK pre-arms it.
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (bus.imem_ack) begin
            ir      <= bus.imem_data;
            req_q   <= 1'b0;
            illegal <= is_undefined(bus.imem_data[OP_HI:OP_LO]);
            state   <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          branch_taken <= (bus.a == '0);
          if (writes_reg(op)) begin
            zero_flag  <= alu_zero;
            carry_flag <= alu_carry;
            bus.Wr     <= ir[RD_HI:RD_LO];
            bus.Wrd    <= alu_result;
            reg_en_q   <= 1'b1;
          end
          state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          pc <= next_pc;
          if (op == OP_HLT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            req_q <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;

  logic clk;
  logic rst_n;
  logic zero_flag, carry_flag, illegal, halted;

  cpu_control_unit_if bus();

  cpu_control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .illegal    (illegal),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- memory and register-set models ----------------
  logic [11:0] mem [32];
  logic [4:0]  regs [4];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          illegal_cycles = 0;

  always_comb bus.imem_data = mem[bus.imem_addr];
  always_comb bus.imem_ack  = bus.imem_req && (wait_cnt == ack_delay);
  always_comb bus.a = regs[bus.Ra];
  always_comb bus.b = regs[bus.Rb];

  always @(posedge clk) begin
    if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (bus.reg_en) regs[bus.Wr] <= bus.Wrd;
  end

  // ---------------- scoreboards ----------------
  typedef struct {
    logic [1:0] wr;
    logic [4:0] wrd;
    logic       z;
    logic       c;
  } wr_exp_t;

  wr_exp_t wq [$];
  int      aq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] enc_r(input logic [3:0] op, input logic [1:0] rd,
                                         input logic [1:0] ra, input logic [1:0] rb);
    return {op, rd, ra, rb, 2'b00};
  endfunction

  function automatic logic [11:0] enc_i(input logic [3:0] op, input logic [1:0] rd,
                                         input logic [4:0] imm);
    return {op, rd, 1'b0, imm};
  endfunction

  function automatic wr_exp_t mk(input logic [1:0] wr, input logic [4:0] wrd,
                                 input logic z, input logic c);
    wr_exp_t e;
    e.wr = wr; e.wrd = wrd; e.z = z; e.c = c;
    return e;
  endfunction

  always @(negedge clk) begin
    if (illegal) illegal_cycles++;
    if (rst_n && bus.reg_en) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 32'(bus.Wr), 32'hFFFF);
      end else begin
        wr_exp_t e;
        e = wq.pop_front();
        check("wb_Wr", 32'(bus.Wr), 32'(e.wr));
        check("wb_Wrd", 32'(bus.Wrd), 32'(e.wrd));
        check("wb_zero", 32'(zero_flag), 32'(e.z));
        check("wb_carry", 32'(carry_flag), 32'(e.c));
        check("wb_no_illegal", 32'(illegal), 32'd0);
      end
    end
    if (rst_n && bus.imem_req && bus.imem_ack) begin
      if (aq.size() == 0) check("unexpected_fetch", 32'(bus.imem_addr), 32'hFFFF);
      else check("fetch_addr", 32'(bus.imem_addr), 32'(aq.pop_front()));
    end
  end

  task automatic wait_fetch(input int addr, input int bound, output int cycles);
    logic hit;
    hit = 1'b0;
    cycles = 0;
    while (!hit && cycles < bound) begin
      @(negedge clk);
      cycles++;
      hit = bus.imem_req && bus.imem_ack && (bus.imem_addr == 5'(addr));
    end
    if (!hit) check("fetch_timeout", 32'(hit), 32'd1);
  endtask

  int cyc;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 12'h000;
    mem[0]  = enc_i(4'h8, 2'd1, 5'd9);        // LDI r1,#9
    mem[1]  = enc_i(4'h8, 2'd2, 5'd27);       // LDI r2,#27
    mem[2]  = enc_r(4'h1, 2'd3, 2'd1, 2'd2);  // ADD r3,r1,r2
    mem[3]  = enc_r(4'h2, 2'd0, 2'd1, 2'd1);  // SUB r0,r1,r1
    mem[4]  = enc_i(4'h9, 2'd0, 5'd20);       // BRZ r0,#20
    mem[20] = 12'hC00;                        // undefined
    mem[21] = enc_r(4'h5, 2'd1, 2'd1, 2'd2);  // XOR r1,r1,r2
    mem[22] = enc_r(4'h6, 2'd2, 2'd1, 2'd0);  // NOT r2,r1
    mem[23] = enc_r(4'h4, 2'd0, 2'd1, 2'd2);  // OR  r0,r1,r2
    mem[24] = enc_r(4'h7, 2'd3, 2'd0, 2'd0);  // MOV r3,r0
    mem[25] = enc_r(4'h3, 2'd1, 2'd0, 2'd2);  // AND r1,r0,r2
    mem[26] = enc_r(4'h1, 2'd2, 2'd0, 2'd0);  // ADD r2,r0,r0
    mem[27] = enc_r(4'h2, 2'd3, 2'd2, 2'd0);  // SUB r3,r2,r0
    mem[28] = enc_i(4'hA, 2'd0, 5'd31);       // JMP #31

    wq.push_back(mk(2'd1, 5'd9,  1'b0, 1'b0));
    wq.push_back(mk(2'd2, 5'd27, 1'b0, 1'b0));
    wq.push_back(mk(2'd3, 5'd4,  1'b0, 1'b1));  // 9+27 = 36 -> 4, carry
    wq.push_back(mk(2'd0, 5'd0,  1'b1, 1'b0));  // 9-9
    wq.push_back(mk(2'd1, 5'd18, 1'b0, 1'b0));  // 9^27
    wq.push_back(mk(2'd2, 5'd13, 1'b0, 1'b0));  // ~18
    wq.push_back(mk(2'd0, 5'd31, 1'b0, 1'b0));  // 18|13
    wq.push_back(mk(2'd3, 5'd31, 1'b0, 1'b0));
    wq.push_back(mk(2'd1, 5'd13, 1'b0, 1'b0));  // 31&13
    wq.push_back(mk(2'd2, 5'd30, 1'b0, 1'b1));  // 62 -> 30, carry
    wq.push_back(mk(2'd3, 5'd31, 1'b0, 1'b1));  // 30-31 -> 31, borrow
    aq = '{0, 1, 2, 3, 4, 20, 21, 22, 23, 24, 25, 26, 27, 28, 31, 0};

    // Reset held
    repeat (3) begin
      @(negedge clk);
      check("rst_reg_en", 32'(bus.reg_en), 32'd0);
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_Wrd", 32'(bus.Wrd), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("first_addr", 32'(bus.imem_addr), 32'd0);

    // Through the ALU sequence, branch taken to 20
    wait_fetch(20, 40, cyc);
    mem[0] = 12'hF00;  // HLT once the pc wraps back
    @(negedge clk);
    check("illegal_decode", 32'(illegal), 32'd1);
    @(negedge clk);
    check("illegal_cleared", 32'(illegal), 32'd0);
    @(negedge clk);
    check("illegal_no_write", 32'(bus.reg_en), 32'd0);

    // Delayed ack on the fetch of 22
    wait_fetch(21, 10, cyc);
    @(posedge clk); #1 ack_delay = 3;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k < 4) begin
        check("slow_req_low", 32'(bus.imem_req), 32'd0);
      end else begin
        check("slow_req_held", 32'(bus.imem_req), 32'd1);
        check("slow_addr_held", 32'(bus.imem_addr), 32'd22);
        check("slow_ack", 32'(bus.imem_ack), 32'(k == 7));
      end
    end
    @(posedge clk); #1 ack_delay = 0;
    wait_fetch(23, 10, cyc);
    check("after_slow_cycles", 32'(cyc), 32'd4);

    // pc wrap 31 -> 0
    wait_fetch(31, 40, cyc);
    wait_fetch(0, 10, cyc);
    check("wrap_cycles", 32'(cyc), 32'd4);

    // HLT
    repeat (3) @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      check("halted", 32'(halted), 32'd1);
      check("halt_req", 32'(bus.imem_req), 32'd0);
    end

    // Reset during WRITEBACK drops the write
    mem[0] = enc_i(4'h8, 2'd1, 5'd5);  // LDI r1,#5
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_exits_halt", 32'(halted), 32'd0);
    aq.push_back(0);
    wait_fetch(0, 10, cyc);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("wb_reset_reg_en", 32'(bus.reg_en), 32'd0);
    @(posedge clk); #1;
    check("wb_reset_pc", 32'(bus.imem_addr), 32'd0);
    check("wb_reset_r1", 32'(regs[1]), 32'd13);
    check("wb_reset_req", 32'(bus.imem_req), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    check("writes_left", 32'(wq.size()), 32'd0);
    check("fetches_left", 32'(aq.size()), 32'd0);
    check("illegal_cycles", 32'(illegal_cycles), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
